// File: rtl/tmu_fml_pkg.sv
// Shared FML burst-port constants and the arbiter state encoding.
package tmu_fml_pkg;
   localparam int FML_BEATS = 4;
   localparam int FML_DW    = 64;
   localparam int FML_SELW  = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANTED = 2'd1,
      BURST   = 2'd2
   } fml_state_t;
endpackage

// File: rtl/tmu_fmlarb_if.sv
// One FML burst port; "master" is the requesting side, "slave" the memory side.
interface tmu_fmlarb_if #(parameter int fml_depth = 26);
   import tmu_fml_pkg::*;

   logic [fml_depth-1:0] adr;
   logic                 stb;
   logic                 we;
   logic [FML_SELW-1:0]  sel;
   logic [FML_DW-1:0]    dout;
   logic                 ack;
   logic [FML_DW-1:0]    din;

   modport master (output adr, stb, we, sel, dout, input ack, din);
   modport slave  (input adr, stb, we, sel, dout, output ack, din);
endinterface

// File: rtl/tmu_fmlarb_mux.sv
// Steers the granted master onto the slave port and routes the ack back to it alone.
module tmu_fmlarb_mux #(
   parameter int fml_depth = 26
) (
   input  logic          grant,
   input  logic          active,
   tmu_fmlarb_if.slave   m0,
   tmu_fmlarb_if.slave   m1,
   tmu_fmlarb_if.master  s
);
   logic [fml_depth-1:0] adr_mux;

   assign adr_mux = grant ? m1.adr : m0.adr;
   assign s.adr   = adr_mux;
   assign s.we    = grant ? m1.we   : m0.we;
   assign s.sel   = grant ? m1.sel  : m0.sel;
   assign s.dout  = grant ? m1.dout : m0.dout;

   // Strobe and ack only pass while a request is being offered, so stray slave acks are dropped.
   assign s.stb   = active & (grant ? m1.stb : m0.stb);
   assign m0.ack  = active & ~grant & s.ack;
   assign m1.ack  = active &  grant & s.ack;

   assign m0.din  = s.din;
   assign m1.din  = s.din;
endmodule

// File: rtl/tmu_fmlarb.sv
// Two-master FML arbiter granting whole 4-beat bursts.
// Define TMU_FMLARB_ROUNDROBIN_EN for round-robin ties; otherwise master 0 always wins ties.
module tmu_fmlarb
   import tmu_fml_pkg::*;
#(
   parameter int fml_depth = 26
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   tmu_fmlarb_if.slave   m0,
   tmu_fmlarb_if.slave   m1,
   tmu_fmlarb_if.master  s
);
`ifdef TMU_FMLARB_ROUNDROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   fml_state_t state;
   logic       grant;
   logic       last;
   logic [1:0] beat_cnt;
   logic       next_grant;
   logic       granted_stb;

   // Ties go to the master that did not win last time, or always to master 0 in fixed mode.
   assign next_grant  = (m0.stb & m1.stb) ? (RR_EN & ~last) : m1.stb;
   assign granted_stb = grant ? m1.stb : m0.stb;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         grant    <= 1'b0;
         last     <= 1'b1;
         beat_cnt <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (m0.stb | m1.stb) begin
                  grant <= next_grant;
                  state <= GRANTED;
               end
            end
            GRANTED: begin
               if (!granted_stb) begin
                  state <= IDLE;
               end else if (s.ack) begin
                  beat_cnt <= 2'(FML_BEATS - 1);
                  last     <= grant;
                  state    <= BURST;
               end
            end
            BURST: begin
               beat_cnt <= beat_cnt - 2'd1;
               if (beat_cnt == 2'd1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   tmu_fmlarb_mux #(.fml_depth(fml_depth)) u_mux (
      .grant  (grant),
      .active (state == GRANTED),
      .m0     (m0),
      .m1     (m1),
      .s      (s)
   );
endmodule
